// File: rtl/spike_synapse_decoder.sv
// Synapse receiver: turns a presynaptic spike train into a leaky weighted current
// and a windowed spike-rate count delivered over a valid/ack handshake.
module spike_synapse_decoder #(
  parameter int WINDOW      = 16,
  parameter int DECAY_SHIFT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spike_in,
  input  logic [4:0] weight,
  output logic [4:0] current,
  output logic [4:0] rate,
  output logic       rate_valid,
  input  logic       rate_ack,
  output logic       overrun
);

  localparam int DATA_W = 5;
  localparam int WCNT_W = $clog2(WINDOW);
  localparam logic [WCNT_W-1:0] WLAST   = WCNT_W'(WINDOW - 1);
  localparam logic [DATA_W-1:0] SAT_MAX = '1;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [WCNT_W-1:0]   wcnt;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W:0]     wadd_p0;
  logic [DATA_W:0]     sum_p0;
  logic [DATA_W:0]     acc_sum_p0;
  logic                wend_p0;

  // All intermediate sums stay below 64, so bit DATA_W alone flags overflow past 31.
  function automatic logic [DATA_W-1:0] sat5(input logic [DATA_W:0] v);
    return v[DATA_W] ? SAT_MAX : v[DATA_W-1:0];
  endfunction

  // A shifted leak of 0 on a nonzero trace is forced to 1 so the trace always reaches 0.
  function automatic logic [DATA_W-1:0] leak_of(input logic [DATA_W-1:0] c);
    logic [DATA_W-1:0] l;
    l = c >> DECAY_SHIFT;
    if ((l == '0) && (c != '0))
      l = DATA_W'(1);
    return l;
  endfunction

  // Stage p0: combinational update terms from the current state and this cycle's spike
  assign wadd_p0    = spike_in ? {1'b0, weight} : '0;
  assign sum_p0     = {1'b0, current} - {1'b0, leak_of(current)} + wadd_p0;
  assign acc_sum_p0 = {1'b0, acc} + {{DATA_W{1'b0}}, spike_in};
  assign wend_p0    = (wcnt == WLAST);

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wend_p0) state_nxt = HOLD;
      HOLD:    if (rate_ack && !wend_p0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rate_valid = (state == HOLD);
  end

  // Stage p1: registered outputs and window bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      current <= '0;
      rate    <= '0;
      overrun <= 1'b0;
      wcnt    <= '0;
      acc     <= '0;
    end else begin
      current <= sat5(sum_p0);
      if (wend_p0) begin
        rate <= sat5(acc_sum_p0);
        acc  <= '0;
        wcnt <= '0;
      end else begin
        acc  <= sat5(acc_sum_p0);
        wcnt <= wcnt + WCNT_W'(1);
      end
      if ((state == HOLD) && wend_p0 && !rate_ack)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spike_synapse_decoder.sv
// Directed scoreboard bench for spike_synapse_decoder (WINDOW=16 and WINDOW=64 instances).
module tb_spike_synapse_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       spike_in;
  logic [4:0] weight;
  logic       rate_ack;
  logic [4:0] current, rate, current64, rate64;
  logic       rate_valid, overrun, rate_valid64, overrun64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  spike_synapse_decoder #(.WINDOW(16), .DECAY_SHIFT(2)) dut (
    .clk(clk), .reset(reset), .spike_in(spike_in), .weight(weight),
    .current(current), .rate(rate), .rate_valid(rate_valid),
    .rate_ack(rate_ack), .overrun(overrun)
  );

  spike_synapse_decoder #(.WINDOW(64), .DECAY_SHIFT(2)) dut64 (
    .clk(clk), .reset(reset), .spike_in(spike_in), .weight(weight),
    .current(current64), .rate(rate64), .rate_valid(rate_valid64),
    .rate_ack(rate_ack), .overrun(overrun64)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [7:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%0d expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; spike_in = 1'b0; rate_ack = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; spike_in = 1'b0; weight = 5'd0; rate_ack = 1'b0;
    step();
    step();

    // Reset state
    sb_push("rst_current", 0); sb_push("rst_rate", 0);
    sb_push("rst_valid", 0);   sb_push("rst_overrun", 0);
    sb_push("rst_current64", 0); sb_push("rst_valid64", 0);
    sb_check(current); sb_check(rate); sb_check(rate_valid); sb_check(overrun);
    sb_check(current64); sb_check(rate_valid64);

    // Single spike decay, weight 8
    reset = 1'b0; weight = 5'd8; spike_in = 1'b1;
    sb_push("decay0", 8); sb_push("decay1", 6); sb_push("decay2", 5);
    sb_push("decay3", 4); sb_push("decay4", 3); sb_push("decay5", 2);
    sb_push("decay6", 1); sb_push("decay7", 0); sb_push("decay8", 0);
    sb_push("decay9", 0);
    step(); spike_in = 1'b0;
    sb_check(current);
    for (int i = 0; i < 9; i++) begin
      step();
      sb_check(current);
    end

    // Rate: spike on every even cycle of a 16-cycle window
    do_reset();
    weight = 5'd1;
    sb_push("even_valid_pre", 0);
    sb_push("even_rate", 8); sb_push("even_valid", 1); sb_push("even_overrun", 0);
    for (int i = 0; i < 16; i++) begin
      spike_in = (i % 2 == 0);
      step();
      if (i == 14) sb_check(rate_valid);
    end
    sb_check(rate); sb_check(rate_valid); sb_check(overrun);

    // Ack clears valid; ack while idle is ignored
    spike_in = 1'b0; rate_ack = 1'b1;
    sb_push("ack_valid", 0); sb_push("ack_rate_hold", 8); sb_push("idle_ack_valid", 0);
    step();
    sb_check(rate_valid); sb_check(rate);
    step();
    sb_check(rate_valid);
    rate_ack = 1'b0;

    // Spike only on the last cycle of the window
    do_reset();
    sb_push("last_rate", 1); sb_push("last_valid", 1);
    for (int i = 0; i < 16; i++) begin
      spike_in = (i == 15);
      step();
    end
    sb_check(rate); sb_check(rate_valid);

    // Overrun: two windows, no ack, 3 then 5 spikes
    do_reset();
    sb_push("ovr_w1_rate", 3); sb_push("ovr_w1_overrun", 0);
    sb_push("ovr_w2_rate", 5); sb_push("ovr_w2_valid", 1); sb_push("ovr_w2_overrun", 1);
    for (int i = 0; i < 16; i++) begin
      spike_in = (i < 3);
      step();
    end
    sb_check(rate); sb_check(overrun);
    for (int i = 0; i < 16; i++) begin
      spike_in = (i < 5);
      step();
    end
    sb_check(rate); sb_check(rate_valid); sb_check(overrun);
    spike_in = 1'b0; rate_ack = 1'b1;
    sb_push("ovr_ack_valid", 0); sb_push("ovr_ack_overrun", 1); sb_push("ovr_ack_rate", 5);
    step();
    sb_check(rate_valid); sb_check(overrun); sb_check(rate);
    rate_ack = 1'b0;

    // Reset mid-window clears everything and restarts the window count
    weight = 5'd3; spike_in = 1'b1;
    sb_push("mid_current_nz", 1);
    for (int i = 0; i < 5; i++) step();
    sb_check(current != 5'd0);
    reset = 1'b1;
    sb_push("mid_rst_current", 0); sb_push("mid_rst_rate", 0);
    sb_push("mid_rst_valid", 0);   sb_push("mid_rst_overrun", 0);
    step();
    sb_check(current); sb_check(rate); sb_check(rate_valid); sb_check(overrun);
    reset = 1'b0;
    sb_push("mid_win_pre_valid", 0); sb_push("mid_win_valid", 1); sb_push("mid_win_rate", 1);
    for (int i = 0; i < 16; i++) begin
      spike_in = (i == 3);
      step();
      if (i == 14) sb_check(rate_valid);
    end
    sb_check(rate_valid); sb_check(rate);

    // Ack coincident with window end while holding
    do_reset();
    sb_push("coin_w1_rate", 2);
    sb_push("coin_rate", 4); sb_push("coin_valid", 1); sb_push("coin_overrun", 0);
    sb_push("coin_ack_valid", 0);
    for (int i = 0; i < 16; i++) begin
      spike_in = (i < 2);
      step();
    end
    sb_check(rate);
    for (int i = 0; i < 16; i++) begin
      spike_in = (i < 4);
      rate_ack = (i == 15);
      step();
    end
    sb_check(rate); sb_check(rate_valid); sb_check(overrun);
    spike_in = 1'b0; rate_ack = 1'b1;
    step();
    sb_check(rate_valid);
    rate_ack = 1'b0;

    // Saturation: weight 31 every cycle; 64-cycle window saturates the rate
    do_reset();
    weight = 5'd31; spike_in = 1'b1;
    sb_push("sat_current1", 31); sb_push("sat_current2", 31);
    sb_push("sat_current64", 31); sb_push("sat_rate64", 31); sb_push("sat_valid64", 1);
    sb_push("sat_overrun64", 0); sb_push("sat_rate16", 16); sb_push("sat_overrun16", 1);
    step(); sb_check(current);
    step(); sb_check(current);
    for (int i = 2; i < 64; i++) step();
    sb_check(current); sb_check(rate64); sb_check(rate_valid64);
    sb_check(overrun64); sb_check(rate); sb_check(overrun);
    spike_in = 1'b0;

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
